wb_slave_mem: RTL

- Wishbone classic-cycle responder backed by a DATA_COUNT-entry register array.
- It is the counterpart to the team's Wishbone test master and the slave end of the dual-master test system.
- It accepts single read/write cycles and responds after a programmable number of wait states.
- It flags accesses outside its decoded window.

---
 rtl/wb_slave_mem.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic-cycle responder backed by a DATA_COUNT-entry
// register array. Each accepted request is acknowledged after WAIT_CYCLES wait
// states. Accesses outside the decoded window set the sticky oor_o flag.
// Optional feature macro WB_SLAVE_MEM_ERR_EN: when defined, adds err_o. An
// out-of-range access then pulses err_o instead of ack_o and leaves dat_o as is.
module wb_slave_mem #(
  parameter int unsigned BASE_ADDRESS = 32'd0,
  parameter int unsigned DATA_WIDTH   = 32'd16,
  parameter int unsigned ADDR_WIDTH   = 32'd16,
  parameter int unsigned DATA_COUNT   = 32'd16,
  parameter int unsigned AU_IN_DATA   = 32'd1,
  parameter int unsigned WAIT_CYCLES  = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
`ifdef WB_SLAVE_MEM_ERR_EN
  output logic                  err_o,
`endif
  output logic                  oor_o
);

  localparam int unsigned IDX_W = (DATA_COUNT > 32'd1) ? $clog2(DATA_COUNT) : 32'd1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] AU_A    = ADDR_WIDTH'(AU_IN_DATA);
  // One extra bit so DATA_COUNT == 2^ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0]   COUNT_A = (ADDR_WIDTH+1)'(DATA_COUNT);
  localparam logic [7:0]            WAIT_L  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  state_r, next_state_s;
  logic [7:0]              cnt_r, cnt_next_s;
  logic [IDX_W-1:0]        idx_r;
  logic                    in_range_r;
  logic                    we_r;
  logic [DATA_WIDTH-1:0]   dat_in_r;
  logic [DATA_WIDTH-1:0]   mem_r [DATA_COUNT];
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack_r;
  logic                    oor_r;
`ifdef WB_SLAVE_MEM_ERR_EN
  logic                    err_r;
`endif

  logic [ADDR_WIDTH-1:0]   off_s, word_s, rem_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    in_range_s;
  logic                    accept_s;
  logic                    commit_s;
  logic [IDX_W-1:0]        c_idx_s;
  logic                    c_in_range_s;
  logic                    c_we_s;
  logic [DATA_WIDTH-1:0]   c_dat_s;

  // Address decode: offset from base, stride check and entry index.
  always_comb begin
    off_s      = adr_i - BASE_A;
    word_s     = off_s / AU_A;
    rem_s      = off_s % AU_A;
    idx_s      = word_s[IDX_W-1:0];
    in_range_s = (adr_i >= BASE_A) && (rem_s == {ADDR_WIDTH{1'b0}}) &&
                 ({1'b0, word_s} < COUNT_A);
  end

  // Next-state logic; commit_s marks the edge that enters S_ACK.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    commit_s     = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          accept_s   = 1'b1;
          cnt_next_s = WAIT_L;
          if (WAIT_L == 8'd0) begin
            next_state_s = S_ACK;
            commit_s     = 1'b1;
          end else begin
            next_state_s = S_WAIT;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!(cyc_i && stb_i)) begin
          next_state_s = S_IDLE;
          cnt_next_s   = 8'd0;
        end else begin
          cnt_next_s = cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            next_state_s = S_ACK;
            commit_s     = 1'b1;
          end else begin
            next_state_s = S_WAIT;
          end
        end
      end
      S_ACK: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Commit operands: live decode for a zero-wait accept, latched values otherwise.
  always_comb begin
    if (state_r == S_IDLE) begin
      c_idx_s      = idx_s;
      c_in_range_s = in_range_s;
      c_we_s       = we_i;
      c_dat_s      = dat_i;
    end else begin
      c_idx_s      = idx_r;
      c_in_range_s = in_range_r;
      c_we_s       = we_r;
      c_dat_s      = dat_in_r;
    end
  end

  // State register, wait counter and request latches (sampled only in S_IDLE).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 8'd0;
      idx_r      <= {IDX_W{1'b0}};
      in_range_r <= 1'b0;
      we_r       <= 1'b0;
      dat_in_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        idx_r      <= idx_s;
        in_range_r <= in_range_s;
        we_r       <= we_i;
        dat_in_r   <= dat_i;
      end
    end
  end

  // Register array: cleared on reset, written only on an in-range commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(DATA_COUNT); k++) begin
        mem_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s && c_in_range_s && c_we_s) begin
      mem_r[c_idx_s] <= c_dat_s;
    end
  end

  // Registered response: ack/err pulse, read data and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_r <= 1'b0;
      dat_r <= {DATA_WIDTH{1'b0}};
      oor_r <= 1'b0;
`ifdef WB_SLAVE_MEM_ERR_EN
      err_r <= 1'b0;
`endif
    end else begin
      ack_r <= 1'b0;
`ifdef WB_SLAVE_MEM_ERR_EN
      err_r <= 1'b0;
`endif
      if (commit_s) begin
        if (c_in_range_s) begin
          ack_r <= 1'b1;
          if (!c_we_s) begin
            dat_r <= mem_r[c_idx_s];
          end
        end else begin
          oor_r <= 1'b1;
`ifdef WB_SLAVE_MEM_ERR_EN
          err_r <= 1'b1;
`else
          ack_r <= 1'b1;
          if (!c_we_s) begin
            dat_r <= {DATA_WIDTH{1'b0}};
          end
`endif
        end
      end
    end
  end

  assign dat_o = dat_r;
  assign ack_o = ack_r;
  assign oor_o = oor_r;
`ifdef WB_SLAVE_MEM_ERR_EN
  assign err_o = err_r;
`endif

endmodule
